// File: rtl/quotient_pack_pkg.sv
// Shared widths, types and keep-mask helper for the quotient packer.
package quotient_pack_pkg;
    localparam int QW     = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = QW * LANES;
    localparam int IDX_W  = $clog2(LANES);
    localparam int CNT_W  = $clog2(LANES + 1);

    typedef logic [LANES-1:0]  keep_t;
    typedef logic [WORD_W-1:0] word_t;

    // Mask with the low n lanes set.
    function automatic keep_t keep_mask(input logic [CNT_W-1:0] n);
        keep_t m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            if (CNT_W'(i) < n) m[i] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/qp_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module qp_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointer advance; caller guarantees push is legal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PTR_W'(1);
            if (i_pop)  r_rd <= r_rd + PTR_W'(1);
        end
    end

    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
endmodule

// File: rtl/quotient_packer.sv
// Packs divider quotients LANES at a time into words and queues them for the
// result writer. Optional idle auto-flush: define QPACK_AUTO_FLUSH_EN.
module quotient_packer
    import quotient_pack_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [QW-1:0] q_in,
    input  logic          q_valid,
    input  logic          flush,
    output word_t         out_data,
    output keep_t         out_keep,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow,
    output logic [15:0]   word_count
);
    logic [IDX_W-1:0] r_idx;
    word_t            r_pack;
    word_t            w_pack_nxt;
    logic [CNT_W-1:0] w_lanes;
    logic             w_complete;
    logic             w_auto;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;

    // Merge the current sample into the pack before deciding whether to push,
    // so a flush in the same cycle carries that sample too.
    always_comb begin
        w_pack_nxt = r_pack;
        if (q_valid) w_pack_nxt[r_idx*QW +: QW] = q_in;
    end

    assign w_lanes    = {1'b0, r_idx} + CNT_W'(q_valid);
    assign w_complete = q_valid && (r_idx == IDX_W'(LANES - 1));
    assign w_push     = w_complete || ((flush || w_auto) && (w_lanes != '0));
    assign w_pop      = !w_empty && out_ready;
    // A full FIFO still takes the word if the head leaves this same cycle.
    assign w_accept   = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;

`ifdef QPACK_AUTO_FLUSH_EN
    localparam int TO_W = $clog2(FLUSH_TIMEOUT + 1);
    logic [TO_W-1:0] r_idle;

    assign w_auto = (r_idx != '0) && !q_valid && (r_idle == TO_W'(FLUSH_TIMEOUT - 1));

    // Idle counter: runs only while a partial word waits with no new sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  r_idle <= '0;
        else if (q_valid || w_push) r_idle <= '0;
        else if (r_idx != '0)       r_idle <= r_idle + TO_W'(1);
    end
`else
    assign w_auto = 1'b0;
`endif

    // Lane index and pack register; a push leaves a clean zeroed pack behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else if (w_push) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else begin
            r_pack <= w_pack_nxt;
            if (q_valid) r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Sticky overflow flag and accepted-word counter (wraps at 2^16).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (w_drop)   overflow   <= 1'b1;
            if (w_accept) word_count <= word_count + 16'd1;
        end
    end

    qp_fifo #(
        .W     (WORD_W + LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  ({keep_mask(w_lanes), w_pack_nxt}),
        .i_pop   (w_pop),
        .o_data  ({out_keep, out_data}),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
endmodule

// File: tb/tb_quotient_packer.sv
// Randomised and directed bench for quotient_packer with a queue-based model.
module tb_quotient_packer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  q_in = '0;
    logic        q_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: byte lanes, a queue of {keep,data} words, counters.
    logic [7:0]  mp [4];
    int          midx;
    int          midle;
    logic [35:0] mq [$];
    logic [15:0] mwc;
    bit          movf;

    quotient_packer #(.DEPTH(4), .FLUSH_TIMEOUT(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .q_in       (q_in),
        .q_valid    (q_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 4; i++) mp[i] = 8'h00;
        midx = 0; midle = 0; mq.delete(); mwc = 16'd0; movf = 1'b0;
    endtask

    task automatic mdl_step(input bit qv, input logic [7:0] q, input bit fl, input bit rdy);
        bit pop, full, autof, fire;
        int pre;
        pre   = midx;
        pop   = (mq.size() > 0) && rdy;
        full  = (mq.size() == 4);
        autof = 1'b0;
        if (qv) begin mp[midx] = q; midx++; end
`ifdef QPACK_AUTO_FLUSH_EN
        if (qv) midle = 0;
        else if (pre > 0) midle++;
        autof = !qv && pre > 0 && midle == 16;
`endif
        fire = (midx == 4) || ((fl || autof) && midx > 0);
        if (pop) void'(mq.pop_front());
        if (fire) begin
            if (!full || pop) begin
                mq.push_back({4'((1 << midx) - 1), mp[3], mp[2], mp[1], mp[0]});
                mwc++;
            end else begin
                movf = 1'b1;
            end
            for (int i = 0; i < 4; i++) mp[i] = 8'h00;
            midx = 0; midle = 0;
        end
    endtask

    // One clock: drive at negedge, model advances with the DUT edge.
    task automatic step(input bit qv, input logic [7:0] q, input bit fl, input bit rdy);
        q_valid = qv; q_in = q; flush = fl; out_ready = rdy;
        @(posedge clock);
        mdl_step(qv, q, fl, rdy);
        @(negedge clock);
    endtask

    task automatic do_reset();
        q_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b1;
        mdl_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            chk("valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("data", out_data, mq[0][31:0]);
                chk("keep", out_keep, mq[0][35:32]);
            end
            chk("overflow", overflow, movf);
            chk("word_count", word_count, mwc);
        end
    end

    initial begin
        mdl_clear();
        @(negedge clock);
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_keep", out_keep, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wc", word_count, 0);
        cmp_en = 1'b1;

        // Full word.
        step(1, 8'h03, 0, 1); step(1, 8'h0D, 0, 1); step(1, 8'h17, 0, 1); step(1, 8'h24, 0, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'h24170D03);
        chk("t1_keep", out_keep, 4'hF);
        chk("t1_wc", word_count, 1);

        // Partial word via flush, then next sample lands in lane 0.
        step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(0, 8'h00, 1, 1);
        chk("t2_data", out_data, 32'h00332211);
        chk("t2_keep", out_keep, 4'h7);
        step(1, 8'h44, 1, 1);
        chk("t2b_data", out_data, 32'h00000044);
        chk("t2b_keep", out_keep, 4'h1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 1);   // flush with nothing pending is a no-op
        chk("t2c_valid", out_valid, 0);

        // Overflow: 5 words into a 4-deep FIFO with no consumer.
        for (int k = 0; k < 20; k++) step(1, 8'(8'h40 + k), 0, 0);
        chk("t3_ovf", overflow, 1);
        chk("t3_wc", word_count, 7);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = {8'(8'h43 + 4*i), 8'(8'h42 + 4*i), 8'(8'h41 + 4*i), 8'(8'h40 + 4*i)};
            chk("t3_drain", out_data, e);
            step(0, 8'h00, 0, 1);
        end
        chk("t3_empty", out_valid, 0);

        // Full FIFO with a pop on the same edge as the completing push.
        do_reset();
        for (int k = 0; k < 19; k++) step(1, 8'(k), 0, 0);
        chk("t4_pre_ovf", overflow, 0);
        step(1, 8'h13, 0, 1);
        chk("t4_ovf", overflow, 0);
        chk("t4_wc", word_count, 5);
        chk("t4_head", out_data, 32'h07060504);

        // Reset mid-word discards the partial lanes.
        do_reset();
        step(1, 8'hEE, 0, 0); step(1, 8'hDD, 0, 0);
        do_reset();
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_keep", out_keep, 0);
        chk("t5_wc", word_count, 0);
        step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0); step(1, 8'hA3, 0, 0); step(1, 8'hA4, 0, 0);
        chk("t5_word", out_data, 32'hA4A3A2A1);
        chk("t5_wkeep", out_keep, 4'hF);

        // Lone sample followed by idle cycles.
        do_reset();
        step(1, 8'h55, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 8'h00, 0, 0);
`ifdef QPACK_AUTO_FLUSH_EN
        chk("t6_valid", out_valid, 1);
        chk("t6_data", out_data, 32'h00000055);
        chk("t6_keep", out_keep, 4'h1);
`else
        chk("t6_valid", out_valid, 0);
`endif

        // Random traffic with alternating consumer pressure.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 19) == 0,
                     $urandom_range(0, 99) < (((i / 200) % 2) ? 85 : 10));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/quotient_packer.md
Name: quotient_packer

Overview:
Downstream consumer of the pipelined divider. Captures each 8-bit quotient qualified by the divider's StartOut strobe and packs four consecutive quotients into one 32-bit word, lane 0 in the LSBs. Buffers packed words in a small FIFO and presents them on a valid/ready interface to the result writer. The divider has no backpressure, so words that arrive while the FIFO is full are dropped and flagged.

Parameters:
QW, 8, quotient width in bits (matches divider q)
LANES, 4, quotients per packed word
DEPTH, 4, FIFO depth in words (power of 2)
FLUSH_TIMEOUT, 16, idle cycles before auto-flush (used only with QPACK_AUTO_FLUSH_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
q_in  input  QW  quotient from divider
q_valid  input  1  divider StartOut; q_in valid this cycle
flush  input  1  push the partial word now
out_data  output  QW*LANES  packed word at FIFO head
out_keep  output  LANES  valid-lane mask for out_data
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts head word
overflow  output  1  sticky: a word was dropped
word_count  output  16  count of words accepted into the FIFO

Behaviour:
- Reset (async, any time, including mid-word): lane index 0, pack register 0, FIFO empty. out_valid=0, out_data=0, out_keep=0, overflow=0, word_count=0. A partial word is discarded.
- Packing: on q_valid, q_in is written into lane[idx] and idx increments. When idx=LANES-1 and q_valid, the completed word (keep all-ones) is pushed and idx returns to 0 in the same cycle.
- Latency: a pushed word appears on out_valid/out_data on the cycle after the push edge.
- flush with a partial word (idx>0): push the partial word with keep = lanes written, unused lanes 0, then idx goes to 0.
- flush with q_valid in the same cycle: include the current sample first, then push. If that sample fills the word, push it once with full keep.
- flush with idx=0 and no q_valid: no-op.
- FIFO handshake: pop when out_valid and out_ready. out_data and out_keep hold stable while out_valid=1 and out_ready=0.
- Full: a push while full is accepted only if a pop occurs in the same cycle. Otherwise the word is dropped, overflow sets and stays set until reset, and word_count does not increment.
- Empty: out_ready is ignored. out_data and out_keep keep their last value; they are don't-care for verification.
- word_count: increments once per accepted push and wraps modulo 2^16.
- Pointers: PTR_W = log2(DEPTH) plus one wrap bit for the full/empty distinction.

Optional Feature:
QPACK_AUTO_FLUSH_EN
- Defined: a counter clears on every q_valid and counts while idx>0 and q_valid=0. When it reaches FLUSH_TIMEOUT, it performs an implicit flush, with the same push/full rules as an explicit flush. The counter is reset to 0 by reset.
- Not defined: no counter logic; partial words leave only via flush or lane completion.

Decomposition:
- Package quotient_pack_pkg: QW, LANES, WORD_W=QW*LANES, a keep-mask typedef, a packed-word typedef, and a function returning the keep mask for a lane count.
- One sub-module, qp_fifo: a synchronous FIFO with width WORD_W+LANES, depth DEPTH, push/pop/full/empty, and the same clock and async active-high reset.
- Packing, flush, overflow and counters stay in quotient_packer.

Test Plan:
- out_ready=1; q_valid pulses with q_in=0x03,0x0D,0x17,0x24 -> one cycle after the 4th, out_valid=1, out_data=0x24170D03, out_keep=0xF, word_count=1.
- Samples 0x11,0x22,0x33, then flush -> out_data=0x00332211, out_keep=0x7; next sample 0x44 lands in lane 0.
- out_ready=0; 20 consecutive samples (5 words), DEPTH=4 -> 4 words held, overflow=1, word_count=4; draining yields the first 4 words in order.
- FIFO full; out_ready=1 in the same cycle the next word completes -> pop and push both occur, overflow stays 0, word_count increments.
- Assert reset after 2 samples for 1 cycle -> all outputs 0. Then 0xA1,0xA2,0xA3,0xA4 -> out_data=0xA4A3A2A1, with no stale lanes.
- Single sample 0x55, then 16 idle cycles -> with QPACK_AUTO_FLUSH_EN: out_data=0x00000055, out_keep=0x1. Without it: out_valid stays 0.
